reg_pipe2: RTL and testbench



---
 rtl/reg_pipe2.sv | 129 ++++++++++++
 tb/tb_reg_pipe2.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/reg_pipe2.sv
// reg_pipe2: two-entry registered pipeline buffer with enq/deq handshake.
// The head slot (data0) drives D_OUT directly, and the skid slot (data1)
// absorbs one extra word. FULL_N, EMPTY_N and D_OUT all come straight from
// flops, so there is no combinational path from any input to any output.

`ifndef BSV_ASSIGNMENT_DELAY
`define BSV_ASSIGNMENT_DELAY
`endif

module reg_pipe2 #(
    parameter int               width = 1,
    parameter logic [width-1:0] init  = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [width-1:0] D_IN,
    input  logic             ENQ,
    output logic             FULL_N,
    output logic [width-1:0] D_OUT,
    input  logic             DEQ,
    output logic             EMPTY_N,
    input  logic             CLR
);

    // Occupancy of the buffer: no entries, head only, or head plus skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [width-1:0] data0;
    logic [width-1:0] data1;
    logic             full_n_q;
    logic             empty_n_q;

    logic             enq_ok;
    logic             deq_ok;
    logic             ld0_din;
    logic             ld0_skid;
    logic             ld1_din;

    // Requests only count when the registered status allows them; a write
    // while full or a read while empty leaves every register untouched.
    assign enq_ok = ENQ & full_n_q;
    assign deq_ok = DEQ & empty_n_q;

    // Next occupancy and which data slot loads what; CLR overrides both
    // handshakes and leaves the data slots as they are.
    always_comb begin
        state_nxt = state;
        ld0_din   = 1'b0;
        ld0_skid  = 1'b0;
        ld1_din   = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (enq_ok) begin
                    ld0_din   = 1'b1;
                    state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (enq_ok && deq_ok) begin
                    // Pass-through: the departing head is replaced in place.
                    ld0_din   = 1'b1;
                    state_nxt = ST_ONE;
                end else if (enq_ok) begin
                    ld1_din   = 1'b1;
                    state_nxt = ST_TWO;
                end else if (deq_ok) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (deq_ok) begin
                    ld0_skid  = 1'b1;
                    state_nxt = ST_ONE;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
        if (CLR) begin
            state_nxt = ST_EMPTY;
            ld0_din   = 1'b0;
            ld0_skid  = 1'b0;
            ld1_din   = 1'b0;
        end
    end

    // Occupancy and status flags; the flags are precomputed from the next
    // occupancy so the ports are driven straight from flops.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= `BSV_ASSIGNMENT_DELAY ST_EMPTY;
            full_n_q  <= `BSV_ASSIGNMENT_DELAY 1'b1;
            empty_n_q <= `BSV_ASSIGNMENT_DELAY 1'b0;
        end else begin
            state     <= `BSV_ASSIGNMENT_DELAY state_nxt;
            full_n_q  <= `BSV_ASSIGNMENT_DELAY (state_nxt != ST_TWO);
            empty_n_q <= `BSV_ASSIGNMENT_DELAY (state_nxt != ST_EMPTY);
        end
    end

    // Head and skid data slots.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data0 <= `BSV_ASSIGNMENT_DELAY init;
            data1 <= `BSV_ASSIGNMENT_DELAY init;
        end else begin
            if (ld0_din) begin
                data0 <= `BSV_ASSIGNMENT_DELAY D_IN;
            end else if (ld0_skid) begin
                data0 <= `BSV_ASSIGNMENT_DELAY data1;
            end
            if (ld1_din) begin
                data1 <= `BSV_ASSIGNMENT_DELAY D_IN;
            end
        end
    end

    assign D_OUT   = data0;
    assign FULL_N  = full_n_q;
    assign EMPTY_N = empty_n_q;

endmodule

// File: tb/tb_reg_pipe2.sv
// tb_reg_pipe2: directed and random stimulus for reg_pipe2 (width=8,
// init=8'hA5), checked against a queue-based FIFO reference of depth two.

module tb_reg_pipe2;

    localparam int         W    = 8;
    localparam logic [7:0] INIT = 8'hA5;

    logic         CLK;
    logic         RST;
    logic [W-1:0] D_IN;
    logic         ENQ;
    logic         FULL_N;
    logic [W-1:0] D_OUT;
    logic         DEQ;
    logic         EMPTY_N;
    logic         CLR;

    int n_checks;
    int n_fail;

    logic [W-1:0] model_q[$];

    reg_pipe2 #(
        .width (W),
        .init  (INIT)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .D_IN    (D_IN),
        .ENQ     (ENQ),
        .FULL_N  (FULL_N),
        .D_OUT   (D_OUT),
        .DEQ     (DEQ),
        .EMPTY_N (EMPTY_N),
        .CLR     (CLR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of stimulus; called #1 after a rising edge, returns #1 after
    // the next one with the reference queue updated and outputs checked.
    task automatic step(input logic enq, input logic [W-1:0] din,
                        input logic deq, input logic clr, input string tag);
        bit           enq_acc;
        bit           deq_acc;
        logic [W-1:0] head;
        ENQ  = enq;
        D_IN = din;
        DEQ  = deq;
        CLR  = clr;
        enq_acc = enq && (model_q.size() < 2);
        deq_acc = deq && (model_q.size() > 0);
        if (deq_acc && !clr) begin
            head = model_q[0];
            check({tag, "_deq_data"}, {24'd0, D_OUT}, {24'd0, head});
        end
        @(posedge CLK);
        #1;
        if (clr) begin
            model_q.delete();
        end else begin
            if (deq_acc) void'(model_q.pop_front());
            if (enq_acc) model_q.push_back(din);
        end
        ENQ = 1'b0;
        DEQ = 1'b0;
        CLR = 1'b0;
        check({tag, "_empty_n"}, {31'd0, EMPTY_N}, {31'd0, (model_q.size() != 0)});
        check({tag, "_full_n"},  {31'd0, FULL_N},  {31'd0, (model_q.size() != 2)});
        if (model_q.size() != 0)
            check({tag, "_head"}, {24'd0, D_OUT}, {24'd0, model_q[0]});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RST  = 1'b0;
        ENQ  = 1'b0;
        DEQ  = 1'b0;
        CLR  = 1'b0;
        D_IN = '0;

        // Reset values held through several edges, then released off-edge.
        #12;
        check("rst_dout",    {24'd0, D_OUT}, {24'd0, INIT});
        check("rst_empty_n", {31'd0, EMPTY_N}, 32'd0);
        check("rst_full_n",  {31'd0, FULL_N},  32'd1);
        #10 RST = 1'b1;
        @(posedge CLK);
        #1;
        check("post_rst_dout",  {24'd0, D_OUT}, {24'd0, INIT});
        check("post_rst_empty", {31'd0, EMPTY_N}, 32'd0);
        check("post_rst_full",  {31'd0, FULL_N},  32'd1);

        // Fill then drain.
        step(1'b1, 8'h11, 1'b0, 1'b0, "fill1");
        check("fill1_latency", {24'd0, D_OUT}, 32'h11);
        step(1'b1, 8'h22, 1'b0, 1'b0, "fill2");
        check("fill2_full_n", {31'd0, FULL_N}, 32'd0);
        check("fill2_dout",   {24'd0, D_OUT}, 32'h11);
        step(1'b0, 8'h00, 1'b1, 1'b0, "drain1");
        check("drain1_dout",  {24'd0, D_OUT}, 32'h22);
        check("drain1_full_n", {31'd0, FULL_N}, 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, "drain2");
        check("drain2_empty", {31'd0, EMPTY_N}, 32'd0);

        // Streaming at one transfer per cycle from one held entry.
        step(1'b1, 8'd1, 1'b0, 1'b0, "stream_pre");
        for (int i = 2; i <= 20; i++) begin
            step(1'b1, 8'(i), 1'b1, 1'b0, "stream");
            check("stream_seq", {24'd0, D_OUT}, i);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, "stream_tail");

        // Overflow ignored, then underflow ignored.
        step(1'b1, 8'h11, 1'b0, 1'b0, "ovf_a");
        step(1'b1, 8'h22, 1'b0, 1'b0, "ovf_b");
        step(1'b1, 8'hFF, 1'b0, 1'b0, "ovf_push");
        step(1'b0, 8'h00, 1'b1, 1'b0, "ovf_d1");
        check("ovf_second", {24'd0, D_OUT}, 32'h22);
        step(1'b0, 8'h00, 1'b1, 1'b0, "ovf_d2");
        step(1'b0, 8'h00, 1'b1, 1'b0, "unf");
        check("unf_empty_n", {31'd0, EMPTY_N}, 32'd0);
        check("unf_full_n",  {31'd0, FULL_N},  32'd1);

        // Clear wins over simultaneous enq/deq while full.
        step(1'b1, 8'h44, 1'b0, 1'b0, "clr_a");
        step(1'b1, 8'h55, 1'b0, 1'b0, "clr_b");
        step(1'b1, 8'h66, 1'b1, 1'b1, "clr");
        check("clr_empty_n", {31'd0, EMPTY_N}, 32'd0);
        check("clr_full_n",  {31'd0, FULL_N},  32'd1);
        step(1'b1, 8'h33, 1'b0, 1'b0, "clr_enq");
        check("clr_enq_dout", {24'd0, D_OUT}, 32'h33);
        step(1'b0, 8'h00, 1'b1, 1'b0, "clr_deq");
        check("clr_deq_empty", {31'd0, EMPTY_N}, 32'd0);

        // Asynchronous reset while full, asserted between edges.
        step(1'b1, 8'h77, 1'b0, 1'b0, "arst_a");
        step(1'b1, 8'h88, 1'b0, 1'b0, "arst_b");
        #2 RST = 1'b0;
        #1;
        model_q.delete();
        check("arst_dout",    {24'd0, D_OUT}, {24'd0, INIT});
        check("arst_empty_n", {31'd0, EMPTY_N}, 32'd0);
        check("arst_full_n",  {31'd0, FULL_N},  32'd1);
        #2 RST = 1'b1;
        @(posedge CLK);
        #1;
        check("arst_hold_dout", {24'd0, D_OUT}, {24'd0, INIT});

        // Random back-pressure with occasional clears.
        for (int c = 0; c < 1000; c++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 49) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
